// File: rtl/text_renderer.sv
// Text-mode pixel pipeline between the VGA timing generator and the character ROM.
// Walks the text buffer in step with the active video window, fetches character codes from
// the text RAM, asks the character ROM for the matching glyph row and serializes it MSB-first
// into a 1-bit pixel stream with a blinking underline cursor. Timing signals are delayed to
// stay aligned with the pixel stream.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   de_in, hs_in, vs_in          timing from the generator (vs_in is an active-high level)
//   tram_addr, tram_readen       text RAM read request (readen is combinational from de_in)
//   tram_data                    text RAM data, valid 1 cycle after the address
//   crom_csel, crom_y,           char ROM glyph select / row select / read enable
//   crom_readen
//   crom_row                     char ROM row, valid 2 cycles after crom_csel
//   cursor_en/col/row            cursor enable and position (text cells)
//   pix_out                      pixel, 1 = foreground
//   de_out, hs_out, vs_out       timing delayed by 4 clk to match pix_out
module text_renderer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned BITS       = 4,
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned ADDRW      = 12,
  parameter int unsigned BLINK_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de_in,
  input  logic             hs_in,
  input  logic             vs_in,
  output logic [ADDRW-1:0] tram_addr,
  output logic             tram_readen,
  input  logic [BITS-1:0]  tram_data,
  output logic [BITS-1:0]  crom_csel,
  output logic [2:0]       crom_y,
  output logic             crom_readen,
  input  logic [WIDTH-1:0] crom_row,
  input  logic             cursor_en,
  input  logic [6:0]       cursor_col,
  input  logic [4:0]       cursor_row,
  output logic             pix_out,
  output logic             de_out,
  output logic             hs_out,
  output logic             vs_out
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (COLS * ROWS > (1 << ADDRW)) begin : g_bad_cfg
    $error("text_renderer: COLS*ROWS does not fit in the text RAM address space");
  end

  // Position counters
  logic [XW-1:0]       xsub_q, xsub_d;
  logic [6:0]          col_q, col_d;
  logic [2:0]          ysub_q, ysub_d;
  logic [4:0]          row_q, row_d;
  logic [ADDRW-1:0]    addr_q, addr_d;
  logic [ADDRW-1:0]    linebase_q, linebase_d;
  logic                de_prev_q, vs_prev_q;
  logic [BLINK_LOG2:0] blink_q, blink_d;

  // Pipeline alignment
  logic [3:0]          de_sr_q, hs_sr_q, vs_sr_q;
  logic [2:0]          ysub_d1_q;
  logic [XW-1:0]       xsub_d1_q, xsub_d2_q, xsub_d3_q;
  logic [2:0]          cur_sr_q;
  logic                pix_q;

  logic                cursor_hit;
  logic [XW-1:0]       bit_idx;
  logic                pix_d;

  always_comb begin
    xsub_d     = xsub_q;
    col_d      = col_q;
    addr_d     = addr_q;
    ysub_d     = ysub_q;
    row_d      = row_q;
    linebase_d = linebase_q;

    if (de_in) begin
      if (xsub_q == XW'(WIDTH - 1)) begin
        xsub_d = '0;
        col_d  = col_q + 7'd1;
        addr_d = addr_q + ADDRW'(1);
      end else begin
        xsub_d = xsub_q + XW'(1);
      end
    end else begin
      // Blanking reloads the start of the current text line.
      xsub_d = '0;
      col_d  = '0;
      addr_d = linebase_q;
    end

    // vsync level wins over the end-of-line step.
    if (vs_in) begin
      ysub_d     = '0;
      row_d      = '0;
      linebase_d = '0;
    end else if (de_prev_q && !de_in) begin
      ysub_d = ysub_q + 3'd1;  // wraps 7 -> 0 naturally
      if (ysub_q == 3'd7) begin
        row_d      = row_q + 5'd1;
        linebase_d = linebase_q + ADDRW'(COLS);
      end
    end

    blink_d = (vs_in && !vs_prev_q) ? blink_q + {{BLINK_LOG2{1'b0}}, 1'b1} : blink_q;
  end

  // Underline on the last glyph row of the cursor cell; visible while blink MSB is 0.
  assign cursor_hit = cursor_en & ~blink_q[BLINK_LOG2] & (ysub_q == 3'd7) &
                      (col_q == cursor_col) & (row_q == cursor_row);

  // Leftmost pixel is the glyph row MSB.
  assign bit_idx = XW'(WIDTH - 1) - xsub_d3_q;
  assign pix_d   = de_sr_q[2] & (crom_row[bit_idx] | cur_sr_q[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xsub_q     <= '0;
      col_q      <= '0;
      ysub_q     <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      linebase_q <= '0;
      de_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      blink_q    <= '0;
      de_sr_q    <= '0;
      hs_sr_q    <= '0;
      vs_sr_q    <= '0;
      ysub_d1_q  <= '0;
      xsub_d1_q  <= '0;
      xsub_d2_q  <= '0;
      xsub_d3_q  <= '0;
      cur_sr_q   <= '0;
      pix_q      <= 1'b0;
    end else begin
      xsub_q     <= xsub_d;
      col_q      <= col_d;
      ysub_q     <= ysub_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      linebase_q <= linebase_d;
      de_prev_q  <= de_in;
      vs_prev_q  <= vs_in;
      blink_q    <= blink_d;
      de_sr_q    <= {de_sr_q[2:0], de_in};
      hs_sr_q    <= {hs_sr_q[2:0], hs_in};
      vs_sr_q    <= {vs_sr_q[2:0], vs_in};
      ysub_d1_q  <= ysub_q;
      xsub_d1_q  <= xsub_q;
      xsub_d2_q  <= xsub_d1_q;
      xsub_d3_q  <= xsub_d2_q;
      cur_sr_q   <= {cur_sr_q[1:0], cursor_hit};
      pix_q      <= pix_d;
    end
  end

  assign tram_addr   = addr_q;
  assign tram_readen = de_in;
  assign crom_csel   = tram_data;
  assign crom_y      = ysub_d1_q;
  assign crom_readen = de_sr_q[0];
  assign pix_out     = pix_q;
  assign de_out      = de_sr_q[3];
  assign hs_out      = hs_sr_q[3];
  assign vs_out      = vs_sr_q[3];

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench for text_renderer. Behavioural text RAM (1-cycle) and char ROM
// (2-cycle) responders; expected pipeline outputs are queued when a cycle is driven and
// popped four cycles later when the DUT presents them.
module tb_text_renderer;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned BITS       = 4;
  localparam int unsigned COLS       = 80;
  localparam int unsigned ROWS       = 30;
  localparam int unsigned ADDRW      = 12;
  localparam int unsigned BLINK_LOG2 = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [ADDRW-1:0] tram_addr;
  logic             tram_readen;
  logic [BITS-1:0]  tram_data = '0;
  logic [BITS-1:0]  crom_csel;
  logic [2:0]       crom_y;
  logic             crom_readen;
  logic [WIDTH-1:0] crom_row = '0;
  logic [WIDTH-1:0] crom_stage = '0;
  logic             cursor_en = 1'b0;
  logic [6:0]       cursor_col = '0;
  logic [4:0]       cursor_row = '0;
  logic             pix_out, de_out, hs_out, vs_out;

  int n_total = 0;
  int n_bad = 0;
  int rom_mode = 0;   // 0: code/row pattern, 1: constant 1010, 2: all zero
  int vs_edges = 0;   // vs rising edges since last reset
  int line_idx = 0;   // raster line since last vs (or reset)
  logic [3:0] exp_q[$];  // {de, hs, vs, pix}
  logic prev_de = 1'b0;
  int   prev_addr = 0;
  int   prev_line = 0;

  text_renderer #(
    .WIDTH(WIDTH), .BITS(BITS), .COLS(COLS), .ROWS(ROWS), .ADDRW(ADDRW),
    .BLINK_LOG2(BLINK_LOG2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .tram_addr(tram_addr), .tram_readen(tram_readen), .tram_data(tram_data),
    .crom_csel(crom_csel), .crom_y(crom_y), .crom_readen(crom_readen), .crom_row(crom_row),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .pix_out(pix_out), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] tram_fn(input logic [11:0] a);
    logic [3:0] t;
    if (a == 12'd0) return 4'h5;
    if (a == 12'd1) return 4'h6;
    t = a[3:0] ^ a[7:4];
    return t + 4'd2;
  endfunction

  function automatic logic [3:0] rom_fn(input logic [3:0] c, input logic [2:0] y);
    if (rom_mode == 1) return 4'b1010;
    if (rom_mode == 2) return 4'b0000;
    return c ^ {y, y[0]};
  endfunction

  // Memory responders
  always @(posedge clk) begin
    if (tram_readen) tram_data <= tram_fn(tram_addr);
    if (crom_readen) crom_stage <= rom_fn(crom_csel, crom_y);
    crom_row <= crom_stage;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic tick(input logic de, input logic hs, input logic vs, input int px);
    int         line;
    int         addr;
    logic [3:0] g;
    logic       cur;
    logic       exp_pix;
    logic [3:0] e;
    line = line_idx;
    if (vs && !vs_in) vs_edges++;
    de_in = de;
    hs_in = hs;
    vs_in = vs;
    addr = (line / 8) * int'(COLS) + px / int'(WIDTH);
    exp_pix = 1'b0;
    if (de) begin
      g = rom_fn(tram_fn(12'(addr)), 3'(line % 8));
      cur = cursor_en && (((vs_edges >> BLINK_LOG2) & 1) == 0) && (line % 8 == 7) &&
            (px / int'(WIDTH) == int'(cursor_col)) && (line / 8 == int'(cursor_row));
      exp_pix = g[int'(WIDTH) - 1 - px % int'(WIDTH)] | cur;
    end
    #4;
    if (de) begin
      check("tram_addr", 32'(tram_addr), 32'(addr));
      check("tram_readen", 32'(tram_readen), 32'd1);
    end
    check("crom_readen", 32'(crom_readen), 32'(prev_de));
    if (prev_de) begin
      check("crom_csel", 32'(crom_csel), 32'(tram_fn(12'(prev_addr))));
      check("crom_y", 32'(crom_y), 32'(prev_line % 8));
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pipe{de,hs,vs,pix}", 32'({de_out, hs_out, vs_out, pix_out}), 32'(e));
    end else begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end
    exp_q.push_back({de, hs, vs, exp_pix});
    prev_de = de;
    prev_addr = addr;
    prev_line = line;
    @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, (i >= 2 && i < 5), 1'b0, 0);
  endtask

  task automatic line_run(input int npx);
    for (int p = 0; p < npx; p++) tick(1'b1, 1'b0, 1'b0, p);
    blank(8);
    line_idx++;
  endtask

  task automatic frame(input int nlines, input int npx);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 0);
    line_idx = 0;
    blank(3);
    for (int l = 0; l < nlines; l++) line_run(npx);
  endtask

  task automatic vs_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, 1'b1, 0);
      tick(1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_tram_addr"}, 32'(tram_addr), 32'd0);
    check({tag, "_crom_y"}, 32'(crom_y), 32'd0);
    check({tag, "_crom_readen"}, 32'(crom_readen), 32'd0);
    check({tag, "_outs"}, 32'({pix_out, de_out, hs_out, vs_out}), 32'd0);
  endtask

  task automatic restart_scoreboard();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b0000);
    prev_de = 1'b0;
    line_idx = 0;
    vs_edges = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    restart_scoreboard();

    // First burst straight after reset: codes 5, 6 and a 1010 glyph row.
    rom_mode = 1;
    blank(2);
    line_run(8);

    // Full-width lines through one text row and into the next.
    rom_mode = 0;
    frame(9, int'(COLS * WIDTH));

    // Cursor underline at cell (2,0) with blank glyphs, across blink phases.
    rom_mode = 2;
    cursor_en = 1'b1;
    cursor_col = 7'd2;
    cursor_row = 5'd0;
    frame(8, 16);
    vs_pulses(16 - vs_edges - 1);
    frame(8, 16);
    vs_pulses(32 - vs_edges - 1);
    frame(8, 16);

    // Reset pulse in the middle of a line.
    rom_mode = 0;
    cursor_en = 1'b0;
    frame(3, 16);
    for (int p = 0; p < 6; p++) tick(1'b1, 1'b0, 1'b0, p);
    de_in = 1'b0;
    hs_in = 1'b0;
    vs_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    check("midreset_tram_readen", 32'(tram_readen), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    restart_scoreboard();
    blank(4);
    line_run(16);
    line_run(16);
    blank(6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
